// File: rtl/apb2axi_pkg.sv
// Shared widths and types for the APB2AXI bridge.
package apb2axi_pkg;

  localparam int unsigned APB_ADDR_W = 32;
  localparam int unsigned APB_DATA_W = 32;

  typedef struct packed {
    logic                  write;
    logic [APB_ADDR_W-1:0] addr;
    logic [APB_DATA_W-1:0] wdata;
  } apb_cmd_t;

  typedef struct packed {
    logic [APB_DATA_W-1:0] rdata;
    logic                  err;
  } apb_rsp_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_RSP = 2'd2,
    DONE     = 2'd3
  } apb_cmp_state_e;

endpackage

// File: rtl/apb2axi_timeout_cnt.sv
// Response watchdog: counts cycles while enabled, flags the last allowed cycle.
module apb2axi_timeout_cnt #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign expired_o = (cnt_q == LAST);

endmodule

// File: rtl/apb2axi_apb_completer.sv
// APB completer front end: turns each APB transfer into one request/response
// exchange toward the AXI side, with window decode and response timeout.
//   state    | meaning
//   IDLE     | waiting for an APB setup phase
//   REQ      | presenting the command (held off while a stale response is owed)
//   WAIT_RSP | command accepted, waiting for the response or the timeout
//   DONE     | one-cycle PREADY pulse with the result
module apb2axi_apb_completer
  import apb2axi_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH     = APB_ADDR_W,
  parameter int unsigned           DATA_WIDTH     = APB_DATA_W,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
  parameter int unsigned           WINDOW_BYTES   = 32'h1000,
  parameter int unsigned           TIMEOUT_CYCLES = 1024
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR,
  output logic                  req_valid,
  input  logic                  req_ready,
  output logic                  req_write,
  output logic [ADDR_WIDTH-1:0] req_addr,
  output logic [DATA_WIDTH-1:0] req_wdata,
  input  logic                  rsp_valid,
  output logic                  rsp_ready,
  input  logic [DATA_WIDTH-1:0] rsp_rdata,
  input  logic                  rsp_err
);

  localparam logic [ADDR_WIDTH-1:0] WIN_MASK = ~ADDR_WIDTH'(WINDOW_BYTES - 1);

  apb_cmp_state_e        state_q;
  logic                  drop_q, drop_d;
  logic                  pready_q, pslverr_q;
  logic [DATA_WIDTH-1:0] prdata_q;
  logic                  req_valid_q, req_write_q;
  logic [ADDR_WIDTH-1:0] req_addr_q;
  logic [DATA_WIDTH-1:0] req_wdata_q;
  logic                  setup, in_window;
  logic                  tmo_clr, tmo_en, tmo_expired;

  assign setup     = PSEL && !PENABLE;
  assign in_window = ((PADDR & WIN_MASK) == BASE_ADDR);
  assign tmo_clr   = (state_q == REQ) && req_valid_q && req_ready;
  assign tmo_en    = (state_q == WAIT_RSP);
  assign rsp_ready = (state_q == WAIT_RSP) || drop_q;

  // A timed-out command still owes us a response; swallow it before issuing again.
  always_comb begin
    drop_d = drop_q;
    if (drop_q && rsp_valid) begin
      drop_d = 1'b0;
    end else if ((state_q == WAIT_RSP) && !rsp_valid && tmo_expired) begin
      drop_d = 1'b1;
    end
  end

  apb2axi_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_tmo (
    .clk_i    (PCLK),
    .rst_ni   (PRESETn),
    .clr_i    (tmo_clr),
    .en_i     (tmo_en),
    .expired_o(tmo_expired)
  );

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= IDLE;
      drop_q      <= 1'b0;
      pready_q    <= 1'b0;
      pslverr_q   <= 1'b0;
      prdata_q    <= '0;
      req_valid_q <= 1'b0;
      req_write_q <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
    end else begin
      drop_q <= drop_d;
      case (state_q)
        IDLE: begin
          if (setup) begin
            req_write_q <= PWRITE;
            req_addr_q  <= PADDR;
            req_wdata_q <= PWDATA;
            if (in_window) begin
              state_q     <= REQ;
              req_valid_q <= !drop_d;
            end else begin
              state_q   <= DONE;
              pready_q  <= 1'b1;
              pslverr_q <= 1'b1;
              prdata_q  <= '0;
            end
          end
        end
        REQ: begin
          if (req_valid_q && req_ready) begin
            state_q     <= WAIT_RSP;
            req_valid_q <= 1'b0;
          end else begin
            req_valid_q <= !drop_d;
          end
        end
        WAIT_RSP: begin
          if (rsp_valid) begin
            state_q   <= DONE;
            pready_q  <= 1'b1;
            pslverr_q <= rsp_err;
            prdata_q  <= req_write_q ? '0 : rsp_rdata;
          end else if (tmo_expired) begin
            state_q   <= DONE;
            pready_q  <= 1'b1;
            pslverr_q <= 1'b1;
            prdata_q  <= '0;
          end
        end
        DONE: begin
          state_q   <= IDLE;
          pready_q  <= 1'b0;
          pslverr_q <= 1'b0;
          prdata_q  <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign PREADY    = pready_q;
  assign PSLVERR   = pslverr_q;
  assign PRDATA    = prdata_q;
  assign req_valid = req_valid_q;
  assign req_write = req_write_q;
  assign req_addr  = req_addr_q;
  assign req_wdata = req_wdata_q;

endmodule

// File: tb/tb_apb2axi_apb_completer.sv
// Directed bench for the APB completer: transaction-level predictor checked
// every cycle, plus hand-computed per-transfer expectations.
module tb_apb2axi_apb_completer;

  localparam int unsigned TB_BASE = 32'h0;
  localparam int unsigned TB_WIN  = 32'h1000;
  localparam int          TB_TMO  = 8;

  logic        PCLK, PRESETn;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic        PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;

  int n_vec = 0;
  int n_err = 0;

  apb2axi_apb_completer #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .BASE_ADDR(32'h0),
    .WINDOW_BYTES(32'h1000), .TIMEOUT_CYCLES(TB_TMO)
  ) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Predictor: a transfer is "open" from an in-window setup until its result
  // is scheduled; it is "sent" once the command has been taken downstream.
  bit          m_open = 0, m_sent = 0, m_drop = 0;
  int          m_waited = 0;
  bit          e_pready = 0, e_err = 0, e_req_valid = 0, e_write = 0, e_rsp_ready = 0;
  logic [31:0] e_rdata = '0, e_addr = '0, e_wdata = '0;

  initial begin
    forever begin
      @(posedge PCLK or negedge PRESETn);
      if (!PRESETn) begin
        m_open = 0; m_sent = 0; m_drop = 0; m_waited = 0;
        e_pready = 0; e_err = 0; e_rdata = '0; e_req_valid = 0;
        e_write = 0; e_addr = '0; e_wdata = '0; e_rsp_ready = 0;
      end else begin
        bit discard, timed_out;
        discard   = m_drop && rsp_valid;
        timed_out = 0;
        if (e_pready) begin
          e_pready = 0; e_err = 0; e_rdata = '0;
        end else if (!m_open) begin
          if (PSEL && !PENABLE) begin
            e_write = PWRITE; e_addr = PADDR; e_wdata = PWDATA;
            if (PADDR >= TB_BASE && PADDR < TB_BASE + TB_WIN) begin
              m_open = 1; m_sent = 0;
            end else begin
              e_pready = 1; e_err = 1; e_rdata = '0;
            end
          end
        end else if (!m_sent) begin
          if (e_req_valid && req_ready) begin
            m_sent = 1; m_waited = 0;
          end
        end else if (rsp_valid) begin
          e_pready = 1; e_err = rsp_err; e_rdata = e_write ? 32'h0 : rsp_rdata;
          m_open = 0;
        end else begin
          m_waited++;
          if (m_waited >= TB_TMO) begin
            e_pready = 1; e_err = 1; e_rdata = '0; m_open = 0; timed_out = 1;
          end
        end
        if (discard) m_drop = 0;
        if (timed_out) m_drop = 1;
        e_req_valid = m_open && !m_sent && !m_drop;
        e_rsp_ready = (m_open && m_sent) || m_drop;
      end
    end
  end

  initial begin
    forever begin
      @(negedge PCLK);
      chk("pready", PREADY, e_pready);
      chk("pslverr", PSLVERR, e_err);
      chk("prdata", PRDATA, e_rdata);
      chk("req_valid", req_valid, e_req_valid);
      chk("rsp_ready", rsp_ready, e_rsp_ready);
      chk("req_write", req_write, e_write);
      chk("req_addr", req_addr, e_addr);
      chk("req_wdata", req_wdata, e_wdata);
    end
  end

  // One APB transfer with a scripted downstream responder. late_at pulses a
  // stray response in that access cycle (used to retire a timed-out command).
  task automatic run_xfer(input string tag, input bit wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input int rdy_dly, input int rsp_dly,
                          input logic [31:0] rdata, input bit err, input int late_at,
                          input int exp_ws, input bit exp_err, input logic [31:0] exp_rdata,
                          input int exp_rv);
    int ws, rv, waited;
    bit hs, hs_now, sent, done, stable, got_err, s_write;
    logic [31:0] got_rdata, s_addr, s_wdata;
    ws = 0; rv = 0; waited = 0; hs = 0; sent = 0; done = 0; stable = 1;
    got_err = 0; got_rdata = '0; s_write = 0; s_addr = '0; s_wdata = '0;
    @(posedge PCLK); #1;
    PSEL = 1; PENABLE = 0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
    @(posedge PCLK); #1;
    PENABLE = 1;
    for (int c = 0; c < 60; c++) begin
      req_ready = 0; rsp_valid = 0; rsp_rdata = '0; rsp_err = 0;
      if (PREADY) begin
        got_rdata = PRDATA; got_err = PSLVERR; done = 1;
        break;
      end
      ws++;
      if (req_valid) begin
        if (rv == 0) begin
          s_addr = req_addr; s_wdata = req_wdata; s_write = req_write;
        end else if (req_addr !== s_addr || req_wdata !== s_wdata || req_write !== s_write) begin
          stable = 0;
        end
        if (rv >= rdy_dly) req_ready = 1;
        rv++;
      end
      if (c == late_at) begin
        rsp_valid = 1; rsp_rdata = 32'hBAD0BAD0; rsp_err = 1;
      end
      if (hs && !sent) begin
        if (waited >= rsp_dly) begin
          rsp_valid = 1; rsp_rdata = rdata; rsp_err = err; sent = 1;
        end
        waited++;
      end
      hs_now = req_ready && req_valid;
      @(posedge PCLK); #1;
      if (hs_now) hs = 1;
    end
    chk({tag, "_completed"}, done, 1);
    chk({tag, "_wait_states"}, ws, exp_ws);
    chk({tag, "_pslverr"}, got_err, exp_err);
    chk({tag, "_prdata"}, got_rdata, exp_rdata);
    chk({tag, "_req_valid_cycles"}, rv, exp_rv);
    if (rv > 0) begin
      chk({tag, "_payload_stable"}, stable, 1);
      chk({tag, "_req_write"}, s_write, wr);
      chk({tag, "_req_addr"}, s_addr, addr);
      chk({tag, "_req_wdata"}, s_wdata, wdata);
    end
  endtask

  initial begin
    PRESETn = 0; PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = '0; PWDATA = '0;
    req_ready = 0; rsp_valid = 0; rsp_rdata = '0; rsp_err = 0;
    repeat (3) @(posedge PCLK);
    #1;
    chk("rst_pready", PREADY, 0);
    chk("rst_pslverr", PSLVERR, 0);
    chk("rst_prdata", PRDATA, 0);
    chk("rst_req_valid", req_valid, 0);
    chk("rst_rsp_ready", rsp_ready, 0);
    chk("rst_req_addr", req_addr, 0);
    PRESETn = 1;
    repeat (2) @(posedge PCLK);

    //       tag       wr addr        wdata         rdy rsp   rdata         err late  ws err rdata         rv
    run_xfer("wr010",  1, 32'h010,  32'hDEADBEEF, 0, 0,    32'hCAFEF00D, 0, -1,   2, 0, 32'h0,        1);
    run_xfer("rd020",  0, 32'h020,  32'h11111111, 3, 4,    32'h12345678, 0, -1,   9, 0, 32'h12345678, 4);
    run_xfer("rd2000", 0, 32'h2000, 32'h0,        0, 0,    32'h0,        0, -1,   0, 1, 32'h0,        0);
    run_xfer("rderr",  0, 32'h040,  32'h0,        0, 1,    32'h0000FFFF, 1, -1,   3, 1, 32'h0000FFFF, 1);
    run_xfer("rdffc",  0, 32'hFFC,  32'h0,        0, 0,    32'hA5A55A5A, 0, -1,   2, 0, 32'hA5A55A5A, 1);
    run_xfer("wr1000", 1, 32'h1000, 32'h01020304, 0, 0,    32'h0,        0, -1,   0, 1, 32'h0,        0);
    run_xfer("tmo",    0, 32'h080,  32'h0,        0, 1000, 32'h00000077, 0, -1,   9, 1, 32'h0,        1);
    run_xfer("drop",   1, 32'h084,  32'h55AA55AA, 0, 0,    32'h00000099, 0, 2,    5, 0, 32'h0,        1);

    // Reset while a command is outstanding.
    @(posedge PCLK); #1;
    PSEL = 1; PENABLE = 0; PWRITE = 0; PADDR = 32'h030;
    @(posedge PCLK); #1;
    PENABLE = 1;
    chk("wait_req_valid_before_rst", req_valid, 1);
    req_ready = 1;
    @(posedge PCLK); #1;
    req_ready = 0;
    chk("wait_rsp_ready_before_rst", rsp_ready, 1);
    #1 PRESETn = 0;
    #1;
    chk("async_rst_req_valid", req_valid, 0);
    chk("async_rst_rsp_ready", rsp_ready, 0);
    chk("async_rst_pready", PREADY, 0);
    chk("async_rst_req_addr", req_addr, 0);
    PSEL = 0; PENABLE = 0;
    repeat (2) @(posedge PCLK);
    #1 PRESETn = 1;

    run_xfer("postrst", 0, 32'h044, 32'h0, 0, 0, 32'h600DF00D, 0, -1, 2, 0, 32'h600DF00D, 1);

    @(posedge PCLK); #1;
    PSEL = 0; PENABLE = 0;
    repeat (3) @(posedge PCLK);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
